wash_cycle_seq: RTL

//  Parametrised multi-phase wash sequencer, successor to the fixed 4-step dishwasher FSM.

---
 rtl/wash_cycle_seq_pkg.sv | 17 +
 rtl/wash_cycle_seq_if.sv | 35 +++
 rtl/wash_cycle_seq_phase_pick.sv | 25 ++
 rtl/wash_cycle_seq.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/wash_cycle_seq_pkg.sv
// Shared constants and state type for the wash cycle sequencer.
package wash_seq_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  localparam int DEF_NUM_PHASES = 4;
  localparam int DEF_TIMER_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_RUN   = RUN,
    ST_PAUSE = PAUSE
  } wash_state_t;

endpackage

// File: rtl/wash_cycle_seq_if.sv
// Panel/timebase inputs and actuator/status outputs of the wash sequencer.
// master = panel side driving requests, slave = sequencer.
interface wash_cycle_seq_if
  import wash_seq_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int TIMER_W    = DEF_TIMER_W
);
  localparam int IDX_W = $clog2(NUM_PHASES);

  logic                          start_but_pressed;
  logic                          pause_req;
  logic                          abort_req;
  logic                          hfminute_tick;
  logic [NUM_PHASES-1:0]         phase_en;
  logic [NUM_PHASES*TIMER_W-1:0] phase_dur;

  logic [NUM_PHASES-1:0]         phase_act;
  logic [IDX_W-1:0]              cur_phase;
  logic [TIMER_W-1:0]            time_left;
  logic                          busy;
  logic                          paused;
  logic                          cycle_done;

  modport master (
    output start_but_pressed, pause_req, abort_req, hfminute_tick, phase_en, phase_dur,
    input  phase_act, cur_phase, time_left, busy, paused, cycle_done
  );

  modport slave (
    input  start_but_pressed, pause_req, abort_req, hfminute_tick, phase_en, phase_dur,
    output phase_act, cur_phase, time_left, busy, paused, cycle_done
  );

endinterface

// File: rtl/wash_cycle_seq_phase_pick.sv
// Finds the lowest set mask bit strictly above base (or anywhere when
// from_start is set, i.e. searching from index -1).
module phase_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic                 from_start,
  input  logic [$clog2(N)-1:0] base,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  // scan high to low so the last qualifying hit is the lowest index
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (from_start || (i > int'(base)))) begin
        found = 1'b1;
        idx   = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/wash_cycle_seq.sv
// Multi-phase wash sequencer: runs enabled phases in index order, each for
// its latched duration in half-minute ticks, with pause/resume and abort.
// All outputs are registered from next-state values.
module wash_cycle_seq
  import wash_seq_pkg::*;
#(
  parameter int NUM_PHASES = DEF_NUM_PHASES,
  parameter int TIMER_W    = DEF_TIMER_W
) (
  input logic             clk,
  input logic             rstb,
  wash_cycle_seq_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PHASES);

  wash_state_t                        st_q, st_n;
  logic [TIMER_W-1:0]                 tmr_q, tmr_n;
  logic [IDX_W-1:0]                   cur_q, cur_n;
  logic [NUM_PHASES-1:0]              en_q, en_n;
  logic [NUM_PHASES-1:0][TIMER_W-1:0] dur_q, dur_n;
  logic [NUM_PHASES-1:0][TIMER_W-1:0] dur_in;
  logic [NUM_PHASES-1:0]              act_q, act_n;
  logic                               busy_q, paused_q, done_q, done_n;

  logic                               first_found, next_found;
  logic [IDX_W-1:0]                   first_idx, next_idx;

  // flat panel bus reinterpreted as one duration per phase
  assign dur_in = bus.phase_dur;

  // first phase of a new cycle comes from the live panel mask
  phase_pick #(.N(NUM_PHASES)) u_first (
    .mask       (bus.phase_en),
    .from_start (1'b1),
    .base       ('0),
    .found      (first_found),
    .idx        (first_idx)
  );

  // successor phase comes from the mask latched at start
  phase_pick #(.N(NUM_PHASES)) u_next (
    .mask       (en_q),
    .from_start (1'b0),
    .base       (cur_q),
    .found      (next_found),
    .idx        (next_idx)
  );

  // next-state, timer and output decode; abort > pause > expiry > tick
  always_comb begin
    st_n   = st_q;
    tmr_n  = tmr_q;
    cur_n  = cur_q;
    en_n   = en_q;
    dur_n  = dur_q;
    done_n = 1'b0;
    act_n  = '0;
    unique case (st_q)
      ST_IDLE: begin
        // first_found doubles as the "mask nonzero" qualifier
        if (bus.start_but_pressed && first_found && !bus.abort_req) begin
          st_n  = ST_RUN;
          en_n  = bus.phase_en;
          dur_n = dur_in;
          cur_n = first_idx;
          tmr_n = dur_in[first_idx];
        end
      end
      ST_RUN: begin
        if (bus.abort_req) begin
          st_n  = ST_IDLE;
          tmr_n = '0;
          cur_n = '0;
        end else if (bus.pause_req) begin
          st_n = ST_PAUSE;
        end else if (tmr_q == '0) begin
          // expiry wins over a coincident tick, so the new phase gets its full time
          if (next_found) begin
            cur_n = next_idx;
            tmr_n = dur_q[next_idx];
          end else begin
            st_n   = ST_IDLE;
            tmr_n  = '0;
            cur_n  = '0;
            done_n = 1'b1;
          end
        end else if (bus.hfminute_tick) begin
          tmr_n = tmr_q - TIMER_W'(1);
        end
      end
      ST_PAUSE: begin
        if (bus.abort_req) begin
          st_n  = ST_IDLE;
          tmr_n = '0;
          cur_n = '0;
        end else if (!bus.pause_req) begin
          st_n = ST_RUN;
        end
      end
      default: begin
        st_n  = ST_IDLE;
        tmr_n = '0;
        cur_n = '0;
      end
    endcase
    if (st_n == ST_RUN) act_n[cur_n] = 1'b1;
  end

  // state, timer, latched config and output registers
  always_ff @(posedge clk) begin
    if (!rstb) begin
      st_q     <= ST_IDLE;
      tmr_q    <= '0;
      cur_q    <= '0;
      en_q     <= '0;
      dur_q    <= '0;
      act_q    <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      st_q     <= st_n;
      tmr_q    <= tmr_n;
      cur_q    <= cur_n;
      en_q     <= en_n;
      dur_q    <= dur_n;
      act_q    <= act_n;
      busy_q   <= (st_n != ST_IDLE);
      paused_q <= (st_n == ST_PAUSE);
      done_q   <= done_n;
    end
  end

  assign bus.phase_act  = act_q;
  assign bus.cur_phase  = cur_q;
  assign bus.time_left  = tmr_q;
  assign bus.busy       = busy_q;
  assign bus.paused     = paused_q;
  assign bus.cycle_done = done_q;

endmodule
